// File: rtl/instruction_memory.sv
// instruction_memory
//
// Responder side of the fetch stage's instruction-read interface. Program
// words live in on-chip RAM. A read returns its word one cycle after the
// address is presented. A byte-serial loader with a valid/ready handshake
// fills the RAM from a host or boot link.
//
// Each 16-bit word is stored as {byte at even address, byte at odd address}.
// That is the order in which the bytes arrive on the stream. The fetch stage
// swaps the two bytes to form the little-endian instruction.
//
// Parameters
//   DEPTH_LOG2  log2 of RAM depth in 16-bit words
//   NOP_WORD    word returned for out-of-range reads and for reads during a load
//
// Ports
//   clock               in   rising-edge clock
//   reset               in   asynchronous, active-high reset
//   instruction_rd1     in   fetch word address
//   instruction_rd1_out out  read data, registered, valid 1 cycle after address
//   fetch_addr_error    out  registered with read data; 1 = address out of range
//   load_start          in   1-cycle pulse that starts a load (honoured only when idle)
//   load_base           in   first word address of the load (taken modulo depth)
//   load_length         in   number of words to load
//   load_data           in   loader byte
//   load_valid          in   load_data is valid
//   load_ready          out  block accepts a byte this cycle
//   load_busy           out  loader is not idle
//   load_done           out  1-cycle pulse when a load completes
module instruction_memory #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [15:0] NOP_WORD   = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] instruction_rd1,
    output logic [15:0] instruction_rd1_out,
    output logic        fetch_addr_error,
    input  logic        load_start,
    input  logic [19:0] load_base,
    input  logic [19:0] load_length,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        load_busy,
    output logic        load_done
);

    localparam int                    DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] wptr;
    logic [19:0]           cnt;
    logic [7:0]            hold_byte;
    logic [15:0]           mem [DEPTH];

    logic                  accept;
    logic                  wr_en_p0;
    logic [15:0]           wr_data_p0;
    logic                  in_range_p0;
    logic [15:0]           rd_data_p1;
    logic                  rd_err_p1;

    // Upper base bits are deliberately dropped: the load address wraps modulo depth.
    logic                  unused_base_bits;
    assign unused_base_bits = ^load_base[19:DEPTH_LOG2];

    assign accept      = load_valid && load_ready;
    assign wr_en_p0    = (state == LO) && accept;
    assign wr_data_p0  = {hold_byte, load_data};
    assign in_range_p0 = (instruction_rd1[19:DEPTH_LOG2] == '0);

    // ---- loader FSM; ready/busy/done are registered alongside the state ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wptr       <= '0;
            cnt        <= '0;
            load_ready <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load_done <= 1'b0;
                    if (load_start) begin
                        wptr      <= load_base[DEPTH_LOG2-1:0];
                        cnt       <= load_length;
                        load_busy <= 1'b1;
                        if (load_length == 20'd0) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state      <= HI;
                            load_ready <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (accept) begin
                        state <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        wptr <= wptr + PTR_ONE;
                        cnt  <= cnt - 20'd1;
                        if (cnt == 20'd1) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state <= HI;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    load_done <= 1'b0;
                    load_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                    load_busy  <= 1'b0;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

    // The even-address byte waits here until its odd partner arrives.
    // The register is data only, so it is not reset; a partial byte left over
    // from an aborted load is never written anywhere.
    always_ff @(posedge clock) begin
        if ((state == HI) && accept) begin
            hold_byte <= load_data;
        end
    end

    // ---- p0 -> RAM write ----
    always_ff @(posedge clock) begin
        if (wr_en_p0) begin
            mem[wptr] <= wr_data_p0;
        end
    end

    // ---- p0 -> p1 read register ----
    // Reads are suppressed while the loader is active. A read and a write
    // therefore never collide on the same word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_p1 <= NOP_WORD;
            rd_err_p1  <= 1'b0;
        end else if (!in_range_p0) begin
            rd_data_p1 <= NOP_WORD;
            rd_err_p1  <= 1'b1;
        end else if (state != IDLE) begin
            rd_data_p1 <= NOP_WORD;
            rd_err_p1  <= 1'b0;
        end else begin
            rd_data_p1 <= mem[instruction_rd1[DEPTH_LOG2-1:0]];
            rd_err_p1  <= 1'b0;
        end
    end

    assign instruction_rd1_out = rd_data_p1;
    assign fetch_addr_error    = rd_err_p1;

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

    localparam logic [15:0] NOP = 16'hBEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] instruction_rd1 = 20'd0;
    logic [15:0] instruction_rd1_out;
    logic        fetch_addr_error;
    logic        load_start = 1'b0;
    logic [19:0] load_base = 20'd0;
    logic [19:0] load_length = 20'd0;
    logic [7:0]  load_data = 8'd0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;

    int vectors = 0;
    int miscompares = 0;

    instruction_memory #(
        .DEPTH_LOG2(10),
        .NOP_WORD  (NOP)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .instruction_rd1    (instruction_rd1),
        .instruction_rd1_out(instruction_rd1_out),
        .fetch_addr_error   (fetch_addr_error),
        .load_start         (load_start),
        .load_base          (load_base),
        .load_length        (load_length),
        .load_data          (load_data),
        .load_valid         (load_valid),
        .load_ready         (load_ready),
        .load_busy          (load_busy),
        .load_done          (load_done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input logic [19:0] base, input logic [19:0] len);
        load_start  = 1'b1;
        load_base   = base;
        load_length = len;
        step();
        load_start  = 1'b0;
    endtask

    // Presents one byte and waits (bounded) until the block accepts it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited     = 0;
        load_data  = b;
        load_valid = 1'b1;
        while (!load_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!load_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_timeout: load_ready=%b required 1", load_ready);
        end
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #2;
        vectors += 5;
        if (instruction_rd1_out !== NOP) begin miscompares++; $display("FAIL reset_out: got %h required %h", instruction_rd1_out, NOP); end
        if (fetch_addr_error !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b required 0", fetch_addr_error); end
        if (load_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b required 0", load_ready); end
        if (load_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", load_busy); end
        if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b required 0", load_done); end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_basic();
        start_load(20'd0, 20'd2);
        vectors += 2;
        if (load_busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b required 1", load_busy); end
        if (load_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready: got %b required 1", load_ready); end
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        vectors++;
        if (load_done !== 1'b1) begin miscompares++; $display("FAIL basic_done_pulse: got %b required 1", load_done); end
        step();
        vectors += 2;
        if (load_done !== 1'b0) begin miscompares++; $display("FAIL basic_done_single: got %b required 0", load_done); end
        if (load_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_clear: got %b required 0", load_busy); end
        instruction_rd1 = 20'd0;
        step();
        vectors += 2;
        if (instruction_rd1_out !== 16'h1122) begin miscompares++; $display("FAIL basic_rd0: got %h required 1122", instruction_rd1_out); end
        if (fetch_addr_error !== 1'b0) begin miscompares++; $display("FAIL basic_rd0_err: got %b required 0", fetch_addr_error); end
        instruction_rd1 = 20'd1;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h3344) begin miscompares++; $display("FAIL basic_rd1: got %h required 3344", instruction_rd1_out); end
    endtask

    task automatic test_back_to_back();
        instruction_rd1 = 20'd0;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h1122) begin miscompares++; $display("FAIL b2b_first: got %h required 1122", instruction_rd1_out); end
        instruction_rd1 = 20'd1;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h3344) begin miscompares++; $display("FAIL b2b_second: got %h required 3344", instruction_rd1_out); end
        instruction_rd1 = 20'd0;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h1122) begin miscompares++; $display("FAIL b2b_third: got %h required 1122", instruction_rd1_out); end
    endtask

    task automatic test_out_of_range();
        instruction_rd1 = 20'h00400;
        step();
        vectors += 2;
        if (instruction_rd1_out !== NOP) begin miscompares++; $display("FAIL oor_data: got %h required %h", instruction_rd1_out, NOP); end
        if (fetch_addr_error !== 1'b1) begin miscompares++; $display("FAIL oor_err: got %b required 1", fetch_addr_error); end
        instruction_rd1 = 20'd1;
        step();
        vectors += 2;
        if (instruction_rd1_out !== 16'h3344) begin miscompares++; $display("FAIL oor_recover_data: got %h required 3344", instruction_rd1_out); end
        if (fetch_addr_error !== 1'b0) begin miscompares++; $display("FAIL oor_recover_err: got %b required 0", fetch_addr_error); end
    endtask

    task automatic test_wrap_and_empty();
        // Base 0xFFFFF: upper bits ignored, so the load starts at word 1023.
        start_load(20'hFFFFF, 20'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        vectors++;
        if (load_done !== 1'b1) begin miscompares++; $display("FAIL wrap_done: got %b required 1", load_done); end
        step();
        instruction_rd1 = 20'd1023;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'hAABB) begin miscompares++; $display("FAIL wrap_word1023: got %h required aabb", instruction_rd1_out); end
        instruction_rd1 = 20'd0;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'hCCDD) begin miscompares++; $display("FAIL wrap_word0: got %h required ccdd", instruction_rd1_out); end
        instruction_rd1 = 20'd1;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h3344) begin miscompares++; $display("FAIL wrap_word1_kept: got %h required 3344", instruction_rd1_out); end

        start_load(20'd0, 20'd0);
        vectors += 3;
        if (load_done !== 1'b1) begin miscompares++; $display("FAIL empty_done: got %b required 1", load_done); end
        if (load_busy !== 1'b1) begin miscompares++; $display("FAIL empty_busy: got %b required 1", load_busy); end
        if (load_ready !== 1'b0) begin miscompares++; $display("FAIL empty_ready: got %b required 0", load_ready); end
        step();
        vectors += 2;
        if (load_done !== 1'b0) begin miscompares++; $display("FAIL empty_done_clear: got %b required 0", load_done); end
        if (load_busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy_clear: got %b required 0", load_busy); end
        instruction_rd1 = 20'd0;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'hCCDD) begin miscompares++; $display("FAIL empty_ram_unchanged: got %h required ccdd", instruction_rd1_out); end
    endtask

    task automatic test_stall();
        start_load(20'd2, 20'd1);
        send_byte(8'h55);
        instruction_rd1 = 20'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors += 4;
            if (load_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b required 1", i, load_ready); end
            if (load_busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy[%0d]: got %b required 1", i, load_busy); end
            if (instruction_rd1_out !== NOP) begin miscompares++; $display("FAIL stall_read[%0d]: got %h required %h", i, instruction_rd1_out, NOP); end
            if (fetch_addr_error !== 1'b0) begin miscompares++; $display("FAIL stall_err[%0d]: got %b required 0", i, fetch_addr_error); end
        end
        send_byte(8'h66);
        vectors++;
        if (load_done !== 1'b1) begin miscompares++; $display("FAIL stall_done: got %b required 1", load_done); end
        step();
        vectors++;
        if (instruction_rd1_out !== NOP) begin miscompares++; $display("FAIL stall_read_in_done: got %h required %h", instruction_rd1_out, NOP); end
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h5566) begin miscompares++; $display("FAIL stall_first_read_after: got %h required 5566", instruction_rd1_out); end
    endtask

    task automatic test_reset_mid_load();
        start_load(20'd0, 20'd4);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        #1 reset = 1'b1;
        #1;
        vectors += 5;
        if (load_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b required 0", load_ready); end
        if (load_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b required 0", load_busy); end
        if (load_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b required 0", load_done); end
        if (instruction_rd1_out !== NOP) begin miscompares++; $display("FAIL midrst_out: got %h required %h", instruction_rd1_out, NOP); end
        if (fetch_addr_error !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b required 0", fetch_addr_error); end
        #1 reset = 1'b0;
        start_load(20'd8, 20'd0);
        vectors++;
        if (load_done !== 1'b1) begin miscompares++; $display("FAIL midrst_restart: got %b required 1", load_done); end
        step();
        instruction_rd1 = 20'd0;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h7788) begin miscompares++; $display("FAIL midrst_word0_kept: got %h required 7788", instruction_rd1_out); end
        instruction_rd1 = 20'd1;
        step();
        vectors++;
        if (instruction_rd1_out !== 16'h3344) begin miscompares++; $display("FAIL midrst_word1_untouched: got %h required 3344", instruction_rd1_out); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_out_of_range();
        test_wrap_and_empty();
        test_stall();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
